// File: rtl/egress_counter.sv
// egress_counter: round-robin drain of destination FIFOs D0/D1, per-port word counters, registered count query.
// Define EGRESS_MISROUTE_CHECK_EN to build the destination-bit check, misroute pulse and cnt_err.
module egress_counter #(
  parameter int BW = 6,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          D0_empty,
  input  logic          D1_empty,
  input  logic [BW-1:0] D0_data_out,
  input  logic [BW-1:0] D1_data_out,
  input  logic          pause,
  input  logic          req,
  input  logic [1:0]    idx,
  output logic          D0_rd,
  output logic          D1_rd,
  output logic [CW-1:0] count_data,
  output logic          count_valid,
  output logic          misroute,
  output logic          idle
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          grant_en;
  logic          ptr_q, ptr_d;
  logic          elig0, elig1;
  logic          cap_v_q, cap_sel_q;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] err_val;
  logic [CW-1:0] count_data_q, count_data_d;
  logic          count_valid_q;
  logic          unused_data;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pause)  state_d = HOLD;
      HOLD:    if (!pause) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    grant_en = 1'b0;
    case (state_q)
      RUN:     grant_en = 1'b1;
      default: grant_en = 1'b0;
    endcase
  end

  assign elig0 = ~D0_empty & ~pause & grant_en;
  assign elig1 = ~D1_empty & ~pause & grant_en;

  // Read strobes depend only on flags, pause and ptr so the FIFOs see them in the grant cycle.
  always_comb begin
    D0_rd = 1'b0;
    D1_rd = 1'b0;
    if (elig0 && elig1) begin
      D0_rd = ~ptr_q;
      D1_rd = ptr_q;
    end else begin
      D0_rd = elig0;
      D1_rd = elig1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (D0_rd) begin
      ptr_d = 1'b1;
    end else if (D1_rd) begin
      ptr_d = 1'b0;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cap_v_q) begin
      if (cap_sel_q) begin
        cnt1_d = cnt1_q + CW'(1);
      end else begin
        cnt0_d = cnt0_q + CW'(1);
      end
    end
  end

`ifdef EGRESS_MISROUTE_CHECK_EN
  logic          cap_dest;
  logic          mis_det;
  logic [CW-1:0] cnt_err_q, cnt_err_d;
  logic          misroute_q;

  assign cap_dest  = cap_sel_q ? D1_data_out[BW-2] : D0_data_out[BW-2];
  assign mis_det   = cap_v_q & (cap_dest != cap_sel_q);
  assign cnt_err_d = cnt_err_q + CW'(mis_det);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_err_q  <= '0;
      misroute_q <= 1'b0;
    end else begin
      cnt_err_q  <= cnt_err_d;
      misroute_q <= mis_det;
    end
  end

  assign misroute = misroute_q;
  assign err_val  = cnt_err_q;
`else
  assign misroute = 1'b0;
  assign err_val  = '0;
`endif

  // Only the destination bit is ever inspected; payload bits pass through untouched.
  assign unused_data = ^{D0_data_out, D1_data_out};

  // Query samples the pre-update counters, so a colliding increment is not yet visible.
  always_comb begin
    count_data_d = count_data_q;
    if (req) begin
      case (idx)
        2'd0:    count_data_d = cnt0_q;
        2'd1:    count_data_d = cnt1_q;
        2'd2:    count_data_d = err_val;
        default: count_data_d = cnt0_q + cnt1_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= 1'b0;
      cap_v_q       <= 1'b0;
      cap_sel_q     <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      count_data_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      cap_v_q       <= D0_rd | D1_rd;
      cap_sel_q     <= D1_rd;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      count_data_q  <= count_data_d;
      count_valid_q <= req;
    end
  end

  assign count_data  = count_data_q;
  assign count_valid = count_valid_q;
  assign idle        = D0_empty & D1_empty & ~cap_v_q;

endmodule

// File: tb/tb_egress_counter.sv
// Bench for egress_counter: FIFO models on both ports, table of drain scenarios, query scoreboard.
module tb_egress_counter;

`ifdef EGRESS_MISROUTE_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D0_empty = 1'b1;
  logic       D1_empty = 1'b1;
  logic [5:0] D0_data_out = '0;
  logic [5:0] D1_data_out = '0;
  logic       pause = 1'b0;
  logic       req = 1'b0;
  logic [1:0] idx = '0;
  logic       D0_rd, D1_rd;
  logic [4:0] count_data;
  logic       count_valid, misroute, idle;

  egress_counter #(.BW(6), .CW(5)) dut (
    .clk(clk), .reset(reset),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .pause(pause), .req(req), .idx(idx),
    .D0_rd(D0_rd), .D1_rd(D1_rd),
    .count_data(count_data), .count_valid(count_valid),
    .misroute(misroute), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n0;
    int         n1;
    bit         bad0;
    int         p_at;
    int         p_len;
    int         pat;
    logic [4:0] e0;
    logic [4:0] e1;
    logic [4:0] eerr;
    logic [4:0] etot;
  } vec_t;

  vec_t       vec[6];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [4:0] sb[$];
  int         glog[$];
  bit         mpend = 1'b0;
  bit         msel = 1'b0;
  logic [5:0] mword = '0;
  logic [4:0] last_exp = '0;
  int         mis_seen = 0;
  bit         ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd_empty();
    D0_empty = (q0.size() == 0);
    D1_empty = (q1.size() == 0);
  endtask

  task automatic push(input bit port, input bit bad);
    logic [5:0] w;
    w = 6'($urandom);
    w[4] = port ^ bad;
    if (port) q1.push_back(w);
    else      q0.push_back(w);
    upd_empty();
  endtask

  // One clock: sample rd mid-cycle, let the edge happen, then play the FIFOs' response.
  task automatic tick();
    bit r0, r1, rq, exp_mis;
    logic [4:0] e;
    #1;
    check("idle", idle, D0_empty & D1_empty & ~mpend);
    r0 = D0_rd;
    r1 = D1_rd;
    rq = req;
    check("rd_onehot", r0 & r1, 0);
    if (pause) check("rd_during_pause", r0 | r1, 0);
    glog.push_back(r0 ? 1 : (r1 ? 2 : 0));
    @(posedge clk);
    #1;
    exp_mis = mpend && MIS_EN && (mword[4] != msel);
    mpend = 1'b0;
    if (r0) begin
      if (q0.size() == 0) begin
        check("pop_empty_d0", 1, 0);
      end else begin
        mword = q0.pop_front();
        D0_data_out = mword;
        mpend = 1'b1;
        msel = 1'b0;
      end
    end
    if (r1) begin
      if (q1.size() == 0) begin
        check("pop_empty_d1", 1, 0);
      end else begin
        mword = q1.pop_front();
        D1_data_out = mword;
        mpend = 1'b1;
        msel = 1'b1;
      end
    end
    upd_empty();
    check("misroute", misroute, exp_mis);
    if (misroute) mis_seen++;
    check("count_valid", count_valid, rq);
    if (rq) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("count_data", count_data, e);
        last_exp = e;
      end
    end else begin
      check("count_hold", count_data, last_exp);
    end
  endtask

  task automatic query(input logic [1:0] k, input logic [4:0] exp);
    req = 1'b1;
    idx = k;
    sb.push_back(exp);
    tick();
    req = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, held across one edge; FIFOs emptied.
  task automatic do_reset();
    req = 1'b0;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    upd_empty();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mpend = 1'b0;
    last_exp = '0;
    mis_seen = 0;
    sb.delete();
    glog.delete();
  endtask

  task automatic drain(input int p_at, input int p_len, output bit done);
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      pause = (i >= p_at) && (i < p_at + p_len);
      if (!pause && q0.size() == 0 && q1.size() == 0 && !mpend) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    pause = 1'b0;
  endtask

  initial begin
    //            n0  n1 bad p_at p_len pat  e0  e1 err tot
    vec[0] = '{3,  0,  0,  0,   0,   1,   3,  0,  0,  3};
    vec[1] = '{4,  4,  0,  0,   0,   2,   4,  4,  0,  8};
    vec[2] = '{0,  33, 0,  0,   0,   0,   0,  1,  0,  1};
    vec[3] = '{1,  0,  1,  0,   0,   0,   1,  0,  1,  1};
    vec[4] = '{6,  6,  0,  3,   5,   0,   6,  6,  0,  12};
    vec[5] = '{20, 20, 0,  0,   0,   2,   20, 20, 0,  8};

    // Reset state with both FIFOs empty
    do_reset();
    check("rst_d0_rd", D0_rd, 0);
    check("rst_d1_rd", D1_rd, 0);
    check("rst_count_data", count_data, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_misroute", misroute, 0);
    check("rst_idle", idle, 1);
    query(2'd3, 5'd0);
    tick();

    foreach (vec[v]) begin
      logic [4:0] eerr;
      do_reset();
      for (int i = 0; i < vec[v].n0; i++) push(1'b0, vec[v].bad0 && (i == 0));
      for (int i = 0; i < vec[v].n1; i++) push(1'b1, 1'b0);
      drain(vec[v].p_at, vec[v].p_len, ok);
      check("drain_done", ok, 1);
      if (vec[v].pat == 1) begin
        for (int k = 0; k < 3; k++) check("d0_consecutive", glog[k], 1);
      end else if (vec[v].pat == 2) begin
        for (int k = 0; k < 8; k++) check("alternate", glog[k], (k % 2 == 1) ? 2 : 1);
      end
      eerr = MIS_EN ? vec[v].eerr : 5'd0;
      check("mis_pulses", mis_seen, eerr);
      query(2'd0, vec[v].e0);
      query(2'd1, vec[v].e1);
      query(2'd2, eerr);
      query(2'd3, vec[v].etot);
      tick();
    end

    // Query in the same cycle as the increment sees the old count
    do_reset();
    push(1'b0, 1'b0);
    tick();
    query(2'd0, 5'd0);
    query(2'd0, 5'd1);

    // Reset in the middle of a busy stream, with a capture pending
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(1'b0, 1'b0);
      push(1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) tick();
    check("pending_before_reset", mpend, 1);
    pause = 1'b1;
    do_reset();
    query(2'd0, 5'd0);
    query(2'd1, 5'd0);
    query(2'd2, 5'd0);
    query(2'd3, 5'd0);
    pause = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
